// File: rtl/wb_master.sv
// Single-outstanding Wishbone-style bus initiator: one strobe/ack cycle per CPU request,
// with optional delayed read-data capture and a no-ack timeout.
module wb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned RD_DLY  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_sel,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [31:0]       dat_o,
    output logic [3:0]        sel_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [2:0]    DLY_INIT = 3'(RD_DLY);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RDWAIT
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [2:0]        dly_q, dly_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            dly_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            dly_q    <= dly_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        dly_d    = dly_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d     = cpu_we;
                    adr_d    = cpu_addr;
                    dat_d    = cpu_wdata;
                    sel_d    = cpu_sel;
                    to_cnt_d = '0;
                    state_d  = BUS;
                end
            end
            BUS: begin
                if (ack_i) begin
                    if (we_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (RD_DLY == 0) begin
                        rdata_d = dat_i;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dly_d   = DLY_INIT;
                        state_d = RDWAIT;
                    end
                end else if (TIMEOUT != 0) begin
                    // Leaving BUS on the terminal count keeps the counter from ever wrapping.
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == TO_MAX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            RDWAIT: begin
                dly_d = (dly_q != 3'd0) ? dly_q - 3'd1 : 3'd0;
                if (dly_q <= 3'd1) begin
                    rdata_d = dat_i;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cyc_d  = (state_d != IDLE);
        stb_d  = (state_d == BUS);
        busy_d = (state_d != IDLE);
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign sel_o     = sel_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: RAM slave with configurable ack delay, a transaction-level timing
// model checked every cycle, and directed scenarios with literal expectations.
module tb_wb_master;

    localparam int unsigned RDD = 1;
    localparam int unsigned TO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_sel = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_busy, cpu_done, cpu_err;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = 32'hFFFF_FFFF;
    logic        ack_i;

    int total = 0;
    int bad   = 0;

    wb_master #(.ADDR_W(32), .RD_DLY(RDD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Slave: RAM with ack after ack_dly strobe cycles; read data is valid only in the
    // cycle following the ack edge and reads all-ones otherwise.
    bit          ack_en = 1'b1;
    int          ack_dly = 0;
    int          wait_cnt = 0;
    logic [31:0] mem [16];

    assign ack_i = ack_en && stb_o && (wait_cnt == ack_dly);

    always @(posedge clk) begin
        if (stb_o && ack_i && we_o)
            for (int b = 0; b < 4; b++)
                if (sel_o[b]) mem[adr_o[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
        dat_i    <= (stb_o && ack_i && !we_o) ? mem[adr_o[5:2]] : 32'hFFFF_FFFF;
        wait_cnt <= (stb_o && !ack_i) ? wait_cnt + 1 : 0;
    end

    // Timing model: each accepted transaction is reduced to the edge indices where the
    // strobe ends and where the done pulse appears.
    int          edge_n = 0;
    bit          m_active = 1'b0;
    int          m_e0 = 0, m_stb_last = 0, m_done_e = 0;
    bit          m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] ref_mem [16];

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_sel    <= '0;
            m_rdata  <= '0;
        end else begin
            if (m_active && edge_n == m_done_e && !m_err && !m_we)
                m_rdata <= ref_mem[m_addr[5:2]];
            if (cpu_req && (!m_active || edge_n > m_done_e)) begin
                m_active <= 1'b1;
                m_e0     <= edge_n;
                m_we     <= cpu_we;
                m_addr   <= cpu_addr;
                m_wdata  <= cpu_wdata;
                m_sel    <= cpu_sel;
                if (ack_en) begin
                    m_stb_last <= edge_n + ack_dly;
                    m_done_e   <= edge_n + ack_dly + 1 + (cpu_we ? 0 : int'(RDD));
                    m_err      <= 1'b0;
                    if (cpu_we)
                        for (int b = 0; b < 4; b++)
                            if (cpu_sel[b]) ref_mem[cpu_addr[5:2]][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end else begin
                    m_stb_last <= edge_n + int'(TO) - 1;
                    m_done_e   <= edge_n + int'(TO);
                    m_err      <= 1'b1;
                end
            end
        end
    end

    int c;
    bit e_busy, e_stb, e_done;

    always @(negedge clk) begin
        if (edge_n > 0) begin
            c      = edge_n - 1;
            e_busy = m_active && c >= m_e0 && c < m_done_e;
            e_stb  = m_active && c >= m_e0 && c <= m_stb_last;
            e_done = m_active && c == m_done_e;
            chk("m_cyc_o",     32'(cyc_o),    32'(e_busy));
            chk("m_stb_o",     32'(stb_o),    32'(e_stb));
            chk("m_cpu_busy",  32'(cpu_busy), 32'(e_busy));
            chk("m_cpu_done",  32'(cpu_done), 32'(e_done));
            chk("m_cpu_err",   32'(cpu_err),  32'(e_done && m_err));
            chk("m_we_o",      32'(we_o),     32'(m_we));
            chk("m_adr_o",     adr_o,         m_addr);
            chk("m_dat_o",     dat_o,         m_wdata);
            chk("m_sel_o",     32'(sel_o),    32'(m_sel));
            chk("m_cpu_rdata", cpu_rdata,     m_rdata);
        end
    end

    // One request pulse; observes until three cycles past the first done pulse.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input bit toggle,
                           output int lat, output int stb_n, output int done_n, output int err_d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_sel = sel;
        lat = -1; stb_n = 0; done_n = 0; err_d = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) cpu_req = 1'b0;
            if (toggle && n == 2) cpu_req = 1'b1;
            if (toggle && n == 3) cpu_req = 1'b0;
            if (stb_o) stb_n++;
            if (cpu_done) begin
                done_n++;
                if (lat < 0) begin
                    lat   = n;
                    err_d = int'(cpu_err);
                end
            end
            if (lat > 0 && n >= lat + 3) break;
        end
        if (lat < 0) chk("done_within_budget", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cyc"},   32'(cyc_o),    32'd0);
        chk({tag, "_stb"},   32'(stb_o),    32'd0);
        chk({tag, "_we"},    32'(we_o),     32'd0);
        chk({tag, "_busy"},  32'(cpu_busy), 32'd0);
        chk({tag, "_done"},  32'(cpu_done), 32'd0);
        chk({tag, "_err"},   32'(cpu_err),  32'd0);
        chk({tag, "_adr"},   adr_o,         32'd0);
        chk({tag, "_dat"},   dat_o,         32'd0);
        chk({tag, "_sel"},   32'(sel_o),    32'd0);
        chk({tag, "_rdata"}, cpu_rdata,     32'd0);
    endtask

    int lat, stb_n, done_n, err_d;
    int stb_mask, done_mask;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Write with combinational ack
        ack_en = 1'b1; ack_dly = 0;
        run_txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, lat, stb_n, done_n, err_d);
        chk("wr_latency", lat, 2);
        chk("wr_stb_cycles", stb_n, 1);
        chk("wr_done_pulses", done_n, 1);
        chk("wr_err", err_d, 0);
        chk("wr_adr_o", adr_o, 32'h10);
        chk("wr_ram_word4", mem[4], 32'h1234_5678);

        // Read back: data registered on ack edge, all-ones in the ack cycle
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, lat, stb_n, done_n, err_d);
        chk("rd_latency", lat, 3);
        chk("rd_done_pulses", done_n, 1);
        chk("rd_rdata", cpu_rdata, 32'h1234_5678);

        // Partial-byte write, then read it with a 3-cycle-late ack and a stray request
        run_txn(1'b1, 32'h18, 32'hA5A5_0F0F, 4'b0101, 1'b0, lat, stb_n, done_n, err_d);
        chk("sel_ram_word6", mem[6], 32'h00A5_000F);
        ack_dly = 3;
        run_txn(1'b0, 32'h18, 32'h0, 4'hF, 1'b1, lat, stb_n, done_n, err_d);
        chk("late_stb_cycles", stb_n, 4);
        chk("late_latency", lat, 6);
        chk("late_done_pulses", done_n, 1);
        chk("late_rdata", cpu_rdata, 32'h00A5_000F);

        // No ack at all: timeout
        ack_en = 1'b0; ack_dly = 0;
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, stb_n, done_n, err_d);
        chk("to_stb_cycles", stb_n, 8);
        chk("to_latency", lat, 9);
        chk("to_err", err_d, 1);
        chk("to_done_pulses", done_n, 1);
        chk("to_rdata_kept", cpu_rdata, 32'h00A5_000F);
        chk("to_cyc_low", 32'(cyc_o), 32'd0);

        // Back-to-back writes with request held high
        ack_en = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF;
        cpu_addr = 32'h0; cpu_wdata = 32'h1111_1111;
        stb_mask = 0; done_mask = 0; done_n = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (stb_o) stb_mask |= (1 << n);
            if (cpu_done) begin
                done_mask |= (1 << n);
                done_n++;
                if (done_n == 1) begin cpu_addr = 32'h4; cpu_wdata = 32'h2222_2222; end
                if (done_n == 2) begin cpu_addr = 32'h8; cpu_wdata = 32'h3333_3333; end
                if (done_n == 3) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("b2b_done_pulses", done_n, 3);
        chk("b2b_stb_cycles", stb_mask, 32'h2A);
        chk("b2b_done_cycles", done_mask, 32'h54);
        chk("b2b_ram0", mem[0], 32'h1111_1111);
        chk("b2b_ram1", mem[1], 32'h2222_2222);
        chk("b2b_ram2", mem[2], 32'h3333_3333);

        // Reset while a read is strobing
        run_txn(1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, 1'b0, lat, stb_n, done_n, err_d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
        @(negedge clk);
        chk("rst_mid_stb_high", 32'(stb_o), 32'd1);
        cpu_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        done_n = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_done) done_n++;
        end
        chk("rst_mid_no_done", done_n, 0);
        run_txn(1'b0, 32'h14, 32'h0, 4'hF, 1'b0, lat, stb_n, done_n, err_d);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", cpu_rdata, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
